serial_frame_deserializer: RTL and testbench

Serial-to-parallel front end for the universal shift register. Collects a framed serial bit stream, one bit per qualified strobe, into an n-bit word and presents it on a valid/ready handshake. The downstream register's parallel-load port (s = 11, I = dout) consumes the word on handshake. Provides abort/restart on a new start-of-frame, overrun flagging, and optional even-parity checking.

---
 rtl/serial_frame_deserializer.sv | 138 +++++++++++++
 tb/tb_serial_frame_deserializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// rtl/serial_frame_deserializer.sv - framed serial-to-parallel collector with valid/ready word output
// Optional even-parity bit per frame when PARITY_CHECK_EN is defined.
module serial_frame_deserializer #(
    parameter int n         = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sin,
    input  logic         sin_vld,
    input  logic         sof,
    output logic [n-1:0] dout,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);
    localparam int CW = $clog2(n + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, OUT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
`endif

    state_t        state, state_nx;
    logic [n-1:0]  shreg, shreg_nx, dout_nx, shifted;
    logic [CW-1:0] cnt, cnt_nx;
    logic          overrun_nx;

`ifdef PARITY_CHECK_EN
    logic perr, perr_nx;
    assign parity_err = perr;
    assign busy       = (state == SHIFT) || (state == PARITY);
`else
    assign parity_err = 1'b0;
    assign busy       = (state == SHIFT);
`endif
    assign dout_vld = (state == OUT);

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        cnt_nx     = cnt;
        dout_nx    = dout;
        overrun_nx = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_nx    = perr;
`endif
        if (MSB_FIRST != 0) shifted = {shreg[n-2:0], sin};
        else                shifted = {sin, shreg[n-1:1]};

        case (state)
            IDLE: begin
                if (sin_vld && sof) begin
                    shreg_nx = shifted;
                    cnt_nx   = CW'(1);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_vld) begin
                    shreg_nx = shifted;
                    if (sof) begin
                        cnt_nx = CW'(1);
                    end else if (cnt == CW'(n - 1)) begin
                        cnt_nx = CW'(n);
`ifdef PARITY_CHECK_EN
                        state_nx = PARITY;
`else
                        state_nx = OUT;
                        dout_nx  = shifted;
`endif
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (sin_vld) begin
                    if (sof) begin
                        shreg_nx = shifted;
                        cnt_nx   = CW'(1);
                        state_nx = SHIFT;
                    end else begin
                        // sin is the parity bit here; the data word is already complete
                        dout_nx  = shreg;
                        perr_nx  = (^shreg) ^ sin;
                        state_nx = OUT;
                    end
                end
            end
`endif
            OUT: begin
                if (dout_rdy) begin
`ifdef PARITY_CHECK_EN
                    perr_nx = 1'b0;
`endif
                    if (sin_vld && sof) begin
                        shreg_nx = shifted;
                        cnt_nx   = CW'(1);
                        state_nx = SHIFT;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end
                end else if (sin_vld) begin
                    overrun_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            dout    <= '0;
            overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr    <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            cnt     <= cnt_nx;
            dout    <= dout_nx;
            overrun <= overrun_nx;
`ifdef PARITY_CHECK_EN
            perr    <= perr_nx;
`endif
        end
    end
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb/tb_serial_frame_deserializer.sv - scoreboard bench for both bit orders against a frame-level model
module tb_serial_frame_deserializer;
    localparam int N = 4;
`ifdef PARITY_CHECK_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic clk = 1'b0, reset_n = 1'b1;
    logic sin = 1'b0, sin_vld = 1'b0, sof = 1'b0, dout_rdy = 1'b0;
    logic [N-1:0] dout_m, dout_l;
    logic vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    serial_frame_deserializer #(.n(N), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset_n(reset_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
        .dout(dout_m), .dout_vld(vld_m), .dout_rdy(dout_rdy), .busy(busy_m),
        .overrun(ovr_m), .parity_err(perr_m));

    serial_frame_deserializer #(.n(N), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset_n(reset_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
        .dout(dout_l), .dout_vld(vld_l), .dout_rdy(dout_rdy), .busy(busy_l),
        .overrun(ovr_l), .parity_err(perr_l));

    typedef struct packed {
        logic [N-1:0] wm;
        logic [N-1:0] wl;
        logic         pe;
    } exp_t;

    // Model: list of bits of the frame being collected plus a one-word holding slot.
    bit           frame[$];
    bit           active, holding, exp_ovr;
    logic [N-1:0] last_m, last_l;
    exp_t         expq[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        frame.delete();
        active  = 1'b0;
        holding = 1'b0;
        exp_ovr = 1'b0;
        last_m  = '0;
        last_l  = '0;
        expq.delete();
    endfunction

    function automatic void model_complete();
        exp_t e;
        bit   p = 1'b0;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.wm[N-1-i] = frame[i];
            e.wl[i]     = frame[i];
        end
        for (int i = 0; i < frame.size(); i++) p ^= frame[i];
`ifdef PARITY_CHECK_EN
        e.pe = p;
`else
        e.pe = 1'b0;
`endif
        expq.push_back(e);
        last_m  = e.wm;
        last_l  = e.wl;
        holding = 1'b1;
        active  = 1'b0;
        frame.delete();
    endfunction

    function automatic void model_step();
        exp_ovr = 1'b0;
        if (holding) begin
            if (dout_rdy) begin
                holding = 1'b0;
                if (sin_vld && sof) begin
                    frame.delete();
                    frame.push_back(sin);
                    active = 1'b1;
                end
            end else if (sin_vld) begin
                exp_ovr = 1'b1;
            end
        end else if (sin_vld) begin
            if (sof) begin
                frame.delete();
                frame.push_back(sin);
                active = 1'b1;
            end else if (active) begin
                frame.push_back(sin);
            end
            if (active && frame.size() == FL) model_complete();
        end
    endfunction

    task automatic cyc(input logic v, input logic s, input logic b, input logic r);
        sin_vld  = v;
        sof      = s;
        sin      = b;
        dout_rdy = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send_frame(input logic [N-1:0] data, input logic par, input logic r,
                              output logic pe);
        for (int i = N - 1; i >= 0; i--) cyc(1'b1, 1'(i == N - 1), data[i], r);
`ifdef PARITY_CHECK_EN
        cyc(1'b1, 1'b0, par, r);
        pe = (^data) ^ par;
`else
        pe = 1'b0 & par;
`endif
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_outputs",
              32'({dout_m, dout_l, vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l}),
              32'(0));
        sin_vld = 1'b0; sof = 1'b0; dout_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            check("dout_vld", 32'({vld_m, vld_l}), 32'({holding, holding}));
            check("busy", 32'({busy_m, busy_l}), 32'({active, active}));
            check("overrun", 32'({ovr_m, ovr_l}), 32'({exp_ovr, exp_ovr}));
            check("dout_hold_m", 32'(dout_m), 32'(last_m));
            check("dout_hold_l", 32'(dout_l), 32'(last_l));
            if (vld_m && dout_rdy) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got word 0x%0h expected none", dout_m);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("sb_word_msb", 32'(dout_m), 32'(e.wm));
                    check("sb_word_lsb", 32'(dout_l), 32'(e.wl));
                    check("sb_parity", 32'({perr_m, perr_l}), 32'({e.pe, e.pe}));
                end
            end
        end
    end

    initial begin
        logic pe;
        model_reset();
        #1;
        do_reset();

        send_frame(4'b1011, 1'b1, 1'b1, pe);
        check("dir_msb_1011", 32'(dout_m), 32'(4'b1011));
        check("dir_lsb_1101", 32'(dout_l), 32'(4'b1101));
        check("dir_parity_a", 32'(perr_m), 32'(pe));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(4'b1011, 1'b0, 1'b1, pe);
        check("dir_parity_b", 32'(perr_m), 32'(pe));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(4'b0010, 1'b1, 1'b1, pe);
        check("dir_abort_0010", 32'(dout_m), 32'(4'b0010));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        send_frame(4'b1011, 1'b1, 1'b0, pe);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("dir_overrun_hold", 32'(dout_m), 32'(4'b1011));
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("dir_same_edge_restart", 32'({busy_m, vld_m}), 32'(2'b10));
        for (int i = 0; i < FL - 1; i++) cyc(1'b1, 1'b0, 1'(i == 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        send_frame(4'b1111, 1'b0, 1'b1, pe);
        check("dir_after_reset_1111", 32'({dout_m, dout_l}), 32'(8'hFF));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 600; k++)
            cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 2),
                1'($urandom), 1'($urandom_range(0, 9) < 6));

        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(expq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
